// File: rtl/reorder_buffer_core.sv
// Reorder buffer: in-order allocation from dispatch, out-of-order completion from
// execute, in-order single-entry retirement with a one-cycle flush on mispredict/exception.
module reorder_buffer_core #(
    parameter int ROB_ENTRIES = 32,
    parameter int IDX_W       = $clog2(ROB_ENTRIES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             alloc_req,
    input  logic [4:0]       alloc_rd,
    input  logic [31:0]      alloc_pc,
    output logic             alloc_ready,
    output logic [IDX_W-1:0] alloc_idx,
    input  logic             ex_valid,
    input  logic [IDX_W-1:0] rob_entry_idx,
    input  logic [31:0]      ex_val,
    input  logic             br_mispred,
    input  logic             exception,
    output logic             commit_valid,
    output logic [4:0]       commit_rd,
    output logic [31:0]      commit_val,
    output logic [31:0]      commit_pc,
    output logic             commit_mispred,
    output logic             commit_exception,
    output logic             flush
);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam logic [IDX_W:0] PTR_ONE = {{IDX_W{1'b0}}, 1'b1};

    state_t             state_reg;
    logic [IDX_W:0]     head_reg;
    logic [IDX_W:0]     tail_reg;
    logic [IDX_W:0]     count;
    logic [IDX_W-1:0]   head_idx;
    logic [IDX_W-1:0]   tail_idx;

    logic [ROB_ENTRIES-1:0] busy_reg;
    logic [ROB_ENTRIES-1:0] done_reg;
    logic [ROB_ENTRIES-1:0] mispred_reg;
    logic [ROB_ENTRIES-1:0] exc_reg;

    logic [4:0]  rd_mem  [ROB_ENTRIES];
    logic [31:0] pc_mem  [ROB_ENTRIES];
    logic [31:0] val_mem [ROB_ENTRIES];

    logic alloc_fire;
    logic complete_fire;
    logic commit_fire;
    logic flush_fire;

    assign head_idx = head_reg[IDX_W-1:0];
    assign tail_idx = tail_reg[IDX_W-1:0];
    assign count    = tail_reg - head_reg;

    // count never exceeds ROB_ENTRIES, so its MSB alone means "full"
    assign alloc_ready = (state_reg == RUN) && !count[IDX_W];
    assign alloc_idx   = tail_idx;

    assign commit_valid     = (state_reg == RUN) && busy_reg[head_idx] && done_reg[head_idx];
    assign commit_rd        = rd_mem[head_idx];
    assign commit_val       = val_mem[head_idx];
    assign commit_pc        = pc_mem[head_idx];
    assign commit_mispred   = commit_valid && mispred_reg[head_idx];
    assign commit_exception = commit_valid && exc_reg[head_idx];
    assign flush            = commit_mispred || commit_exception;

    assign flush_fire    = flush;
    assign commit_fire   = commit_valid && !flush;
    assign alloc_fire    = alloc_req && alloc_ready && !flush;
    assign complete_fire = ex_valid && (state_reg == RUN) && busy_reg[rob_entry_idx] && !flush;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= RUN;
            head_reg  <= '0;
            tail_reg  <= '0;
        end else begin
            case (state_reg)
                RUN: begin
                    if (flush_fire) begin
                        head_reg  <= '0;
                        tail_reg  <= '0;
                        state_reg <= FLUSH;
                    end else begin
                        if (commit_fire) head_reg <= head_reg + PTR_ONE;
                        if (alloc_fire)  tail_reg <= tail_reg + PTR_ONE;
                    end
                end
                FLUSH:   state_reg <= RUN;
                default: state_reg <= RUN;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < ROB_ENTRIES; gi++) begin : g_entry
            localparam logic [IDX_W-1:0] SLOT = IDX_W'(gi);

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    busy_reg[gi]    <= 1'b0;
                    done_reg[gi]    <= 1'b0;
                    mispred_reg[gi] <= 1'b0;
                    exc_reg[gi]     <= 1'b0;
                end else if (flush_fire) begin
                    busy_reg[gi] <= 1'b0;
                end else begin
                    if (alloc_fire && (tail_idx == SLOT)) begin
                        busy_reg[gi]    <= 1'b1;
                        done_reg[gi]    <= 1'b0;
                        mispred_reg[gi] <= 1'b0;
                        exc_reg[gi]     <= 1'b0;
                    end
                    if (complete_fire && (rob_entry_idx == SLOT)) begin
                        done_reg[gi]    <= 1'b1;
                        mispred_reg[gi] <= br_mispred;
                        exc_reg[gi]     <= exception;
                    end
                    if (commit_fire && (head_idx == SLOT)) begin
                        busy_reg[gi] <= 1'b0;
                    end
                end
            end
        end
    endgenerate

    // Payload needs no reset: it is only observed alongside a busy, done head entry
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            rd_mem[tail_idx] <= alloc_rd;
            pc_mem[tail_idx] <= alloc_pc;
        end
        if (complete_fire) begin
            val_mem[rob_entry_idx] <= ex_val;
        end
    end

endmodule

// File: tb/tb_reorder_buffer_core.sv
// Self-checking bench for reorder_buffer_core: directed scenarios plus random traffic,
// all checked every cycle against a counter/array model of the buffer.
module tb_reorder_buffer_core;

    localparam int N = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alloc_req;
    logic [4:0]  alloc_rd;
    logic [31:0] alloc_pc;
    logic        alloc_ready;
    logic [4:0]  alloc_idx;
    logic        ex_valid;
    logic [4:0]  rob_entry_idx;
    logic [31:0] ex_val;
    logic        br_mispred;
    logic        exception;
    logic        commit_valid;
    logic [4:0]  commit_rd;
    logic [31:0] commit_val;
    logic [31:0] commit_pc;
    logic        commit_mispred;
    logic        commit_exception;
    logic        flush;

    reorder_buffer_core #(.ROB_ENTRIES(N)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .alloc_req        (alloc_req),
        .alloc_rd         (alloc_rd),
        .alloc_pc         (alloc_pc),
        .alloc_ready      (alloc_ready),
        .alloc_idx        (alloc_idx),
        .ex_valid         (ex_valid),
        .rob_entry_idx    (rob_entry_idx),
        .ex_val           (ex_val),
        .br_mispred       (br_mispred),
        .exception        (exception),
        .commit_valid     (commit_valid),
        .commit_rd        (commit_rd),
        .commit_val       (commit_val),
        .commit_pc        (commit_pc),
        .commit_mispred   (commit_mispred),
        .commit_exception (commit_exception),
        .flush            (flush)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Model: monotonic head/tail counters (reset to 0 on flush) and per-slot contents
    int          mh = 0;
    int          mt = 0;
    bit          m_fl = 1'b0;
    bit          m_done [N];
    bit          m_mis  [N];
    bit          m_exc  [N];
    logic [4:0]  m_rd   [N];
    logic [31:0] m_pc   [N];
    logic [31:0] m_val  [N];

    function automatic bit m_busy(input int idx);
        return (((idx - (mh % N)) + N) % N) < (mt - mh);
    endfunction

    function automatic bit m_cv();
        return !m_fl && ((mt - mh) > 0) && m_done[mh % N];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        int  s;
        bit  cv;
        bit  fl;
        s  = mh % N;
        cv = m_cv();
        fl = cv && (m_mis[s] || m_exc[s]);
        if (!rst_n) begin
            mh   = 0;
            mt   = 0;
            m_fl = 1'b0;
        end else if (m_fl) begin
            m_fl = 1'b0;
        end else if (fl) begin
            mh   = 0;
            mt   = 0;
            m_fl = 1'b1;
        end else begin
            if (ex_valid && m_busy(int'(rob_entry_idx))) begin
                m_done[rob_entry_idx] = 1'b1;
                m_val[rob_entry_idx]  = ex_val;
                m_mis[rob_entry_idx]  = br_mispred;
                m_exc[rob_entry_idx]  = exception;
            end
            if (alloc_req && ((mt - mh) < N)) begin
                m_done[mt % N] = 1'b0;
                m_mis[mt % N]  = 1'b0;
                m_exc[mt % N]  = 1'b0;
                m_rd[mt % N]   = alloc_rd;
                m_pc[mt % N]   = alloc_pc;
                mt++;
            end
            if (cv) mh++;
        end
    end

    always @(negedge clk) begin
        int s;
        bit cv;
        if (chk_en) begin
            s  = mh % N;
            cv = m_cv();
            chk("alloc_ready", {31'b0, alloc_ready}, {31'b0, !m_fl && ((mt - mh) < N)});
            chk("alloc_idx", {27'b0, alloc_idx}, 32'(mt % N));
            chk("commit_valid", {31'b0, commit_valid}, {31'b0, cv});
            chk("flush", {31'b0, flush}, {31'b0, cv && (m_mis[s] || m_exc[s])});
            if (cv) begin
                chk("commit_rd", {27'b0, commit_rd}, {27'b0, m_rd[s]});
                chk("commit_val", commit_val, m_val[s]);
                chk("commit_pc", commit_pc, m_pc[s]);
                chk("commit_mispred", {31'b0, commit_mispred}, {31'b0, m_mis[s]});
                chk("commit_exception", {31'b0, commit_exception}, {31'b0, m_exc[s]});
                $display("commit idx=%0d rd=%0d pc=%h val=%h mis=%0b exc=%0b",
                         s, commit_rd, commit_pc, commit_val, commit_mispred, commit_exception);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_alloc(input logic [4:0] rd, input logic [31:0] pc);
        alloc_req = 1'b1;
        alloc_rd  = rd;
        alloc_pc  = pc;
        cyc();
        alloc_req = 1'b0;
    endtask

    task automatic do_comp(input int idx, input logic [31:0] v, input bit mis, input bit exc);
        ex_valid      = 1'b1;
        rob_entry_idx = 5'(idx);
        ex_val        = v;
        br_mispred    = mis;
        exception     = exc;
        cyc();
        ex_valid   = 1'b0;
        br_mispred = 1'b0;
        exception  = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        int idx;
        int cnt;
        rst_n = 1'b0; alloc_req = 1'b0; alloc_rd = '0; alloc_pc = '0;
        ex_valid = 1'b0; rob_entry_idx = '0; ex_val = '0; br_mispred = 1'b0; exception = 1'b0;
        cyc();
        cyc();
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Reset values
        chk("rst_alloc_ready", {31'b0, alloc_ready}, 32'd1);
        chk("rst_alloc_idx", {27'b0, alloc_idx}, 32'd0);
        chk("rst_commit_valid", {31'b0, commit_valid}, 32'd0);
        chk("rst_flush", {31'b0, flush}, 32'd0);

        // Basic in-order flow: complete 2, 0, 1
        for (int i = 0; i < 3; i++) begin
            chk("basic_alloc_idx", {27'b0, alloc_idx}, 32'(i));
            do_alloc(5'(i + 1), 32'h1000 + 32'(4 * i));
        end
        do_comp(2, 32'h22, 1'b0, 1'b0);
        chk("basic_no_early_commit", {31'b0, commit_valid}, 32'd0);
        do_comp(0, 32'h00, 1'b0, 1'b0);
        chk("basic_c0_valid", {31'b0, commit_valid}, 32'd1);
        chk("basic_c0_val", commit_val, 32'h00);
        do_comp(1, 32'h11, 1'b0, 1'b0);
        chk("basic_c1_val", commit_val, 32'h11);
        cyc();
        chk("basic_c2_val", commit_val, 32'h22);
        chk("basic_c2_pc", commit_pc, 32'h1008);
        cyc();
        chk("basic_done", {31'b0, commit_valid}, 32'd0);

        // Full buffer starting from head=tail=3
        for (int i = 0; i < N; i++) do_alloc(5'(i), 32'h3000 + 32'(i));
        chk("full_not_ready", {31'b0, alloc_ready}, 32'd0);
        alloc_req = 1'b1;
        cyc();
        alloc_req = 1'b0;
        chk("full_tail_kept", {27'b0, alloc_idx}, 32'd3);
        do_comp(3, 32'h33, 1'b0, 1'b0);
        chk("full_commit", {31'b0, commit_valid}, 32'd1);
        cyc();
        chk("full_ready_again", {31'b0, alloc_ready}, 32'd1);
        for (int k = 1; k < N; k++) do_comp((3 + k) % N, 32'(k), 1'b0, 1'b0);
        cyc();
        cyc();

        // Wrap-around from a clean buffer
        do_reset();
        for (int i = 0; i < 40; i++) begin
            chk("wrap_alloc_idx", {27'b0, alloc_idx}, 32'(i % N));
            do_alloc(5'(i), 32'h4000 + 32'(i));
            do_comp(i % N, 32'(i), 1'b0, 1'b0);
            chk("wrap_commit_val", commit_val, 32'(i));
            cyc();
        end

        // Mispredict flush
        do_reset();
        for (int i = 0; i < 5; i++) do_alloc(5'(i), 32'h5000 + 32'(i));
        do_comp(1, 32'h51, 1'b1, 1'b0);
        do_comp(0, 32'h50, 1'b0, 1'b0);
        chk("mis_c0_flush", {31'b0, flush}, 32'd0);
        chk("mis_c0_pc", commit_pc, 32'h5000);
        cyc();
        chk("mis_c1_mispred", {31'b0, commit_mispred}, 32'd1);
        chk("mis_c1_flush", {31'b0, flush}, 32'd1);
        cyc();
        chk("mis_flush_not_ready", {31'b0, alloc_ready}, 32'd0);
        ex_valid = 1'b1; rob_entry_idx = 5'd3; ex_val = 32'h99; alloc_req = 1'b1;
        cyc();
        ex_valid = 1'b0; alloc_req = 1'b0;
        chk("mis_resume_ready", {31'b0, alloc_ready}, 32'd1);
        chk("mis_resume_idx", {27'b0, alloc_idx}, 32'd0);
        chk("mis_late_ignored", {31'b0, commit_valid}, 32'd0);

        // Exception with same-cycle allocation and completion
        for (int i = 0; i < 3; i++) do_alloc(5'(i + 8), 32'h6000 + 32'(i));
        do_comp(0, 32'h60, 1'b0, 1'b1);
        chk("exc_commit_exception", {31'b0, commit_exception}, 32'd1);
        chk("exc_flush", {31'b0, flush}, 32'd1);
        alloc_req = 1'b1; ex_valid = 1'b1; rob_entry_idx = 5'd1; ex_val = 32'h61;
        cyc();
        alloc_req = 1'b0; ex_valid = 1'b0;
        chk("exc_flush_not_ready", {31'b0, alloc_ready}, 32'd0);
        cyc();
        chk("exc_count_zero_idx", {27'b0, alloc_idx}, 32'd0);
        chk("exc_no_commit", {31'b0, commit_valid}, 32'd0);

        // Invalid completion, then reset inside a FLUSH cycle
        do_comp(7, 32'h77, 1'b0, 1'b0);
        chk("inv_no_commit", {31'b0, commit_valid}, 32'd0);
        chk("inv_idx", {27'b0, alloc_idx}, 32'd0);
        do_alloc(5'd3, 32'h7000);
        do_comp(0, 32'h70, 1'b1, 1'b0);
        chk("rf_flush", {31'b0, flush}, 32'd1);
        cyc();
        chk("rf_in_flush", {31'b0, alloc_ready}, 32'd0);
        do_reset();
        chk("rf_alloc_ready", {31'b0, alloc_ready}, 32'd1);
        chk("rf_alloc_idx", {27'b0, alloc_idx}, 32'd0);
        chk("rf_commit_valid", {31'b0, commit_valid}, 32'd0);
        chk("rf_flush_low", {31'b0, flush}, 32'd0);
        chk("rf_mispred", {31'b0, commit_mispred}, 32'd0);
        chk("rf_exception", {31'b0, commit_exception}, 32'd0);

        // Random traffic
        for (int n = 0; n < 2000; n++) begin
            alloc_req = ($urandom_range(0, 3) != 0);
            alloc_rd  = 5'($urandom);
            alloc_pc  = $urandom;
            cnt = mt - mh;
            if (cnt > 0 && $urandom_range(0, 4) != 0)
                idx = (mh + int'($urandom_range(0, cnt - 1))) % N;
            else
                idx = int'($urandom_range(0, N - 1));
            ex_valid      = ($urandom_range(0, 1) == 1) && !(alloc_req && idx == (mt % N));
            rob_entry_idx = 5'(idx);
            ex_val        = $urandom;
            br_mispred    = ($urandom_range(0, 40) == 0);
            exception     = ($urandom_range(0, 60) == 0);
            rst_n         = ($urandom_range(0, 700) != 0);
            cyc();
        end
        rst_n = 1'b1; alloc_req = 1'b0; ex_valid = 1'b0;
        cyc();
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reorder_buffer_core.md
# reorder_buffer_core

Reorder buffer that sits at the receiving end of the execute→ROB completion interface. It allocates entries in program order from dispatch and accepts out-of-order completions from execute: `ex_valid`, `rob_entry_idx`, `ex_val`, `br_mispred` and `exception`. It retires entries strictly in order, one per cycle. A retiring entry that carries a branch mispredict or an exception raises a pipeline flush.

## Interface
- ROB_ENTRIES, 32, number of entries; must be a power of two, ≥ 4
- IDX_W, $clog2(ROB_ENTRIES), entry index width
- clk  input  1  core clock
- rst_n  input  1  synchronous reset, active-low
- alloc_req  input  1  dispatch requests one entry this cycle
- alloc_rd  input  5  destination register of the dispatched instruction
- alloc_pc  input  32  PC of the dispatched instruction
- alloc_ready  output  1  an entry can be allocated this cycle
- alloc_idx  output  IDX_W  index given to the allocation when alloc_req && alloc_ready
- ex_valid  input  1  execute completion strobe
- rob_entry_idx  input  IDX_W  entry being completed
- ex_val  input  32  result value
- br_mispred  input  1  completed instruction was a mispredicted branch
- exception  input  1  completed instruction raised an exception
- commit_valid  output  1  head entry retires this cycle
- commit_rd  output  5  retiring destination register
- commit_val  output  32  retiring result
- commit_pc  output  32  retiring PC
- commit_mispred  output  1  retiring entry mispredicted
- commit_exception  output  1  retiring entry excepted
- flush  output  1  commit_valid && (commit_mispred || commit_exception)

## Operation
- State per entry: busy, done, mispred, exc, rd, pc, val.
- Pointers head and tail are IDX_W+1 bits; the MSB is a wrap bit.
- count = tail − head, computed modulo 2^(IDX_W+1).
- FSM states are RUN and FLUSH. Reset puts the FSM in RUN.
- Allocate (RUN only):
  - alloc_ready = (state==RUN) && (count < ROB_ENTRIES). It does not depend on a same-cycle commit.
  - alloc_idx = tail[IDX_W-1:0].
  - On alloc_req && alloc_ready, the entry is written with busy=1, done=0, mispred=0, exc=0, and tail increments.
- Complete (RUN only):
  - On ex_valid to a busy entry, the entry takes done=1, val=ex_val, mispred=br_mispred, exc=exception.
  - ex_valid to a non-busy entry is ignored.
  - ex_valid in FLUSH is ignored.
  - Completion of an entry allocated in the same cycle is impossible by construction. Behaviour for it is undefined.
- Commit:
  - commit_valid = (state==RUN) && entry[head].busy && entry[head].done.
  - All commit_* outputs are combinational from the registered head entry.
  - On a commit without flush, the entry's busy bit is cleared and head increments.
- Flush:
  - On commit with flush=1, every entry's busy bit is cleared and head and tail are set to 0, so count becomes 0.
  - Any same-cycle allocation or completion is discarded.
  - The FSM goes to FLUSH.
- FLUSH lasts exactly one cycle, with alloc_ready=0 and commit_valid=0, then the FSM returns to RUN.
- Simultaneous allocate and commit in RUN: tail and head both advance, and count is unchanged.
- Wrap-around: indices wrap modulo ROB_ENTRIES, and the wrap bit distinguishes full from empty.
- Reset values: head=0, tail=0, all busy=0, state=RUN.
  - Outputs after reset: alloc_ready=1, alloc_idx=0, commit_valid=0, flush=0, commit_mispred=0, commit_exception=0.
  - commit_rd, commit_val and commit_pc reflect entry 0 and are don't-care while commit_valid=0.

## Timing
- Allocation to commit takes at least 1 cycle after the completion of the head entry.
- Completion accepted at edge N: commit_valid can assert in cycle N+1 at the earliest.
- One retirement per cycle at most. A run of completed entries retires back-to-back.
- flush is high for exactly the one cycle of the faulting commit.
- alloc_ready is low in the following FLUSH cycle, and allocation resumes the cycle after that with alloc_idx=0.
- Reset (rst_n=0 at an edge) aborts any operation, including a FLUSH cycle. The next cycle shows the reset values.

## Test plan
- Basic in-order flow:
  - Stimulus: allocate 3 entries (idx 0,1,2), complete them in order 2, 0, 1 with ex_val 0x22, 0x00, 0x11.
  - Required: commits occur in order 0, 1, 2 on consecutive cycles, with commit_val 0x00, 0x11, 0x22. The entry-0 commit comes one cycle after its completion.
- Full buffer:
  - Stimulus: 32 allocations with no completions.
  - Required: alloc_ready=0 after the 32nd. A 33rd alloc_req is not accepted and tail is unchanged.
  - Then complete entry 0: commit occurs and alloc_ready=1 the next cycle.
- Wrap-around:
  - Stimulus: allocate and retire 40 instructions one at a time.
  - Required: alloc_idx sequence is 0..31, 0..7. Commits stay in order, and no full/empty false indication occurs.
- Mispredict flush:
  - Stimulus: allocate 5 entries, complete entry 1 with br_mispred=1, then entry 0.
  - Required: entry 0 commits normally. Entry 1 commits with flush=1.
  - The next cycle has alloc_ready=0, and a late ex_valid to idx 3 is ignored.
  - The following cycle has alloc_ready=1 and alloc_idx=0.
- Exception with simultaneous events:
  - Stimulus: head has exc=1 and is done; in the same cycle alloc_req=1 and ex_valid to another entry.
  - Required: commit_exception=1 and flush=1. The allocation and completion are discarded, and count is 0 after the edge.
- Invalid completion and reset:
  - Stimulus: ex_valid to non-busy idx 7.
  - Required: no state change.
  - Then assert rst_n=0 during a FLUSH cycle: all outputs return to reset values the next cycle.
